// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note-on/off events to voices (retrigger, free, steal-oldest)
// and applies a linear release ramp on each envelope tick.
//
// state  | meaning
// IDLE   | ready for an event; ev_ready high
// SCAN   | examining one voice per cycle, idx 0..N_VOICES-1
// COMMIT | writes the chosen voice (note-on) or clears matching gates (note-off)
`timescale 1ns/1ps
module voice_allocator #(
    parameter int N_VOICES = 8,
    parameter int STAMP_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [7:0]                   ev_key,
    input  logic [31:0]                  ev_frequency,
    input  logic [31:0]                  ev_volume,
    input  logic                         tick,
    input  logic [31:0]                  release_step,
    output logic [N_VOICES-1:0][31:0]    frequencies,
    output logic [N_VOICES-1:0][31:0]    voice_volumes,
    output logic [N_VOICES-1:0]          voice_active
);
    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]                 idx;
    logic                             accept;
    logic                             last_idx;

    logic                             lat_note_on;
    logic [7:0]                       lat_key;
    logic [31:0]                      lat_freq;
    logic [31:0]                      lat_vol;

    logic [N_VOICES-1:0][7:0]         key;
    logic [N_VOICES-1:0]              gate;
    logic [N_VOICES-1:0][STAMP_W-1:0] stamp;
    logic [STAMP_W-1:0]               seq;

    logic                             retrig_found, free_found;
    logic [IDX_W-1:0]                 retrig_idx, free_idx, steal_idx, tgt_idx;
    logic [STAMP_W-1:0]               steal_age, cur_age;

    logic [N_VOICES-1:0][7:0]         key_nxt;
    logic [N_VOICES-1:0]              gate_nxt;
    logic [N_VOICES-1:0][STAMP_W-1:0] stamp_nxt;
    logic [N_VOICES-1:0][31:0]        freq_nxt;
    logic [N_VOICES-1:0][31:0]        vol_nxt;
    logic [N_VOICES-1:0]              active_nxt;
    logic [STAMP_W-1:0]               seq_nxt;
    logic                             do_note_on;

    assign accept   = ev_valid & ev_ready;
    assign last_idx = (idx == IDX_W'(N_VOICES - 1));
    assign cur_age  = seq - stamp[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (last_idx) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ev_ready = (state == IDLE);
    end

    // Event latch and per-voice candidate search, one voice per SCAN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            lat_note_on  <= 1'b0;
            lat_key      <= '0;
            lat_freq     <= '0;
            lat_vol      <= '0;
            retrig_found <= 1'b0;
            retrig_idx   <= '0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            steal_idx    <= '0;
            steal_age    <= '0;
        end else if (accept) begin
            idx          <= '0;
            lat_note_on  <= ev_note_on;
            lat_key      <= ev_key;
            lat_freq     <= ev_frequency;
            lat_vol      <= ev_volume;
            retrig_found <= 1'b0;
            free_found   <= 1'b0;
            steal_idx    <= '0;
            steal_age    <= '0;
        end else if (state == SCAN) begin
            idx <= idx + IDX_W'(1);
            if (!retrig_found && gate[idx] && (key[idx] == lat_key)) begin
                retrig_found <= 1'b1;
                retrig_idx   <= idx;
            end
            if (!free_found && !gate[idx] && (voice_volumes[idx] == '0)) begin
                free_found <= 1'b1;
                free_idx   <= idx;
            end
            // strict compare keeps the lowest index on equal ages
            if ((idx == '0) || (cur_age > steal_age)) begin
                steal_idx <= idx;
                steal_age <= cur_age;
            end
        end
    end

    always_comb begin
        tgt_idx    = retrig_found ? retrig_idx : (free_found ? free_idx : steal_idx);
        do_note_on = (state == COMMIT) && lat_note_on;
        seq_nxt    = do_note_on ? seq + STAMP_W'(1) : seq;
        key_nxt    = key;
        gate_nxt   = gate;
        stamp_nxt  = stamp;
        freq_nxt   = frequencies;
        vol_nxt    = voice_volumes;
        active_nxt = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (do_note_on && (tgt_idx == IDX_W'(i))) begin
                freq_nxt[i]  = lat_freq;
                vol_nxt[i]   = lat_vol;
                key_nxt[i]   = lat_key;
                gate_nxt[i]  = 1'b1;
                stamp_nxt[i] = seq;
            end else begin
                if (tick && !gate[i] && (voice_volumes[i] != '0)) begin
                    vol_nxt[i] = (voice_volumes[i] <= release_step) ? '0
                                 : voice_volumes[i] - release_step;
                end
                if ((state == COMMIT) && !lat_note_on && gate[i] && (key[i] == lat_key)) begin
                    gate_nxt[i] = 1'b0;
                end
            end
            active_nxt[i] = gate_nxt[i] | (vol_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key           <= '0;
            gate          <= '0;
            stamp         <= '0;
            seq           <= '0;
            frequencies   <= '0;
            voice_volumes <= '0;
            voice_active  <= '0;
        end else begin
            key           <= key_nxt;
            gate          <= gate_nxt;
            stamp         <= stamp_nxt;
            seq           <= seq_nxt;
            frequencies   <= freq_nxt;
            voice_volumes <= vol_nxt;
            voice_active  <= active_nxt;
        end
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler in front of the 8-voice time-multiplexed Synthesizer.
- Accepts note-on/note-off events through a valid/ready handshake and assigns each note to a voice (free voice first, otherwise steals the oldest).
- Drives the per-voice `frequencies` and `voice_volumes` arrays the synthesizer consumes.
- Applies a linear release ramp per voice on an envelope tick strobe.

Parameters:
- N_VOICES, 8, number of voices; must match the synthesizer voice count.
- STAMP_W, 16, width of the note-on sequence stamp used for age/stealing.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event present
- ev_ready  out  1  allocator can accept an event this cycle
- ev_note_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  8  note identifier, matched on note-off and retrigger
- ev_frequency  in  32  frequency for note-on, Hz, integer
- ev_volume  in  32  initial volume for note-on
- tick  in  1  envelope step strobe, one-cycle pulse
- release_step  in  32  volume decrement per tick for releasing voices
- frequencies  out  32 x N_VOICES  per-voice frequency to synthesizer
- voice_volumes  out  32 x N_VOICES  per-voice volume to synthesizer
- voice_active  out  N_VOICES  voice gated or volume != 0

Behaviour:
- Reset, asynchronous: all `frequencies`, `voice_volumes`, keys, stamps and gates = 0; `voice_active` = 0; sequence counter = 0; FSM = IDLE; `ev_ready` = 1.
- A reset during SCAN/COMMIT aborts the event with no output change.
- Per-voice state: key[7:0], gate, stamp[STAMP_W-1:0], plus the two output registers.
- A voice is free when gate = 0 and volume = 0.

FSM:
- IDLE: `ev_ready` = 1. On `ev_valid` & `ev_ready`, latch the event fields and go to SCAN with index = 0.
- SCAN: one voice examined per cycle, index 0..N_VOICES-1, then go to COMMIT. `ev_ready` = 0.
- COMMIT: one cycle; update state and outputs, then go to IDLE.
- After an accept edge, `ev_ready` is low for exactly N_VOICES+1 cycles.
- Outputs change at the COMMIT clock edge, N_VOICES+1 cycles after the accept edge.

Note-on selection, priority highest first:
1. Retrigger: the lowest-index voice with gate = 1 and key == ev_key.
2. The lowest-index free voice.
3. Steal: the voice with the largest age = (seq - stamp) mod 2^STAMP_W; ties go to the lowest index.

Note-on commit on the chosen voice:
- frequency := ev_frequency; volume := ev_volume; key := ev_key; gate := 1; stamp := seq.
- Then seq := seq + 1, wrapping.

Note-off:
- Every voice with gate = 1 and key == ev_key gets gate := 0; volume and frequency are untouched.
- No match: no state change, but the handshake timing is identical.

Release ramp:
- On a `tick` cycle, every voice with gate = 0 and volume != 0 gets: volume := (volume <= release_step) ? 0 : volume - release_step.
- Applied in parallel in any FSM state.
- A COMMIT write to the same voice in the same cycle wins; the tick is not applied to that voice.
- release_step = 0 holds volume; the voice stays non-free but remains stealable.

Other rules:
- Gated voices hold volume constant; there is no attack or decay stage.
- `frequencies` hold their last value after release, so the oscillator keeps running silently.
- `voice_active`[i] = gate[i] | (volume[i] != 0), registered with the state.
- All arithmetic is unsigned 32-bit with no wrap below 0.
- Stamp wrap is handled by the modular age computation.

Test Plan:
- Reset: assert `rst_n` = 0 mid-SCAN, release -> all volumes/frequencies 0, `voice_active` = 0x00, `ev_ready` = 1 next cycle, no event committed.
- Basic note-on: key 60, freq 440, vol 0x1000 -> `ev_ready` low 9 cycles; `frequencies`[0] = 440, `voice_volumes`[0] = 0x1000 at the 9th edge after accept; `voice_active` = 0x01.
- Stealing: note-on keys 60..67, then key 70 freq 880 -> voices 0..7 filled in order; key 70 lands on voice 0; `frequencies`[0] = 880, others unchanged.
- Release: voice 2 at 0x1000, note-off key 62, release_step 0x400, 4 ticks -> volume 0xC00, 0x800, 0x400, 0; `voice_active`[2] falls with the 4th tick; a following note-on reuses voice 2 if it is the lowest free.
- Retrigger: note-on key 60 twice while gated (vol 0x1000, then 0x2000) -> same voice index, `voice_volumes` = 0x2000, no second voice active.
- Collision: tick coincident with a COMMIT edge to a releasing voice at 0x800 with step 0x400 -> the committed ev_volume is written, not ev_volume-0x400; other releasing voices still decrement.
